// File: rtl/toggle_arb_pkg.sv
// Shared types and limits for the toggle-resource round-robin scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package toggle_arb_pkg;

   localparam int TOGGLE_ARB_MAX_NREQ = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      APPLY = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/toggle_state_fsm.sv
// Two-state toggle resource; in=1 flips the state on the next rising edge.
// Latency: one cycle from in to out.
// Backpressure: none, accepts a flip every cycle.
module toggle_state_fsm #(
   parameter bit RESET_STATE = 1'b1
) (
   input  logic clk,
   input  logic areset,
   input  logic in,
   output logic out
);

   logic state_q;
   logic state_d;

   always_comb begin
      state_d = in ? ~state_q : state_q;
   end

   always_ff @(posedge clk) begin
      if (areset) begin
         state_q <= RESET_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   assign out = state_q;

endmodule

// File: rtl/toggle_arb_sched.sv
// Round-robin scheduler granting exclusive access to one toggle resource; optional hold via TOGGLE_ARB_LOCK_EN.
// Latency: gnt cycles 1-3 after req seen in IDLE, done and post-toggle state_out at cycle 3.
// Backpressure: one transaction per 3 cycles; other requesters wait for their round-robin turn.
module toggle_arb_sched
   import toggle_arb_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter bit RESET_STATE = 1'b1
) (
   input  logic            clk,
   input  logic            areset,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] toggle_en,
`ifdef TOGGLE_ARB_LOCK_EN
   input  logic [NREQ-1:0] lock,
`endif
   output logic [NREQ-1:0] gnt,
   output logic            done,
   output logic            state_out,
   output logic            busy
);

   localparam int IW = $clog2(NREQ);

   arb_state_t      state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic            ten_q, ten_d;
   logic            tog_in;
   logic            hold;
   logic [NREQ-1:0] req_arb;
   logic [IW:0]     pick;

   // MSB of the result flags a winner; low bits carry its index.
   function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
      logic [IW:0] res;
      int          j;
      res = '0;
      for (int i = 0; i < TOGGLE_ARB_MAX_NREQ; i++) begin
         if (i < NREQ) begin
            j = int'(p) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!res[IW] && r[j]) res = {1'b1, j[IW-1:0]};
         end
      end
      return res;
   endfunction

   function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] i);
      if (int'(i) >= NREQ - 1) return '0;
      return i + IW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (areset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         ptr_q   <= '0;
         ten_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         ten_q   <= ten_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      ten_d   = ten_q;
`ifdef TOGGLE_ARB_LOCK_EN
      hold    = lock[idx_q];
`else
      hold    = 1'b0;
`endif
      // The finishing requester's own req is not a fresh request in RESP.
      req_arb = req;
      if (state_q == RESP) req_arb[idx_q] = 1'b0;
      pick    = rr_pick(req_arb, ptr_q);

      case (state_q)
         IDLE: begin
            if (pick[IW]) begin
               idx_d   = pick[IW-1:0];
               ptr_d   = ptr_inc(pick[IW-1:0]);
               state_d = GRANT;
            end
         end
         GRANT: begin
            ten_d   = toggle_en[idx_q];
            state_d = APPLY;
         end
         APPLY: begin
            state_d = RESP;
         end
         RESP: begin
            if (hold) begin
               state_d = GRANT;
            end else if (pick[IW]) begin
               idx_d   = pick[IW-1:0];
               ptr_d   = ptr_inc(pick[IW-1:0]);
               state_d = GRANT;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt = '0;
      if (state_q != IDLE) gnt[idx_q] = 1'b1;
      done   = (state_q == RESP);
      busy   = (state_q != IDLE);
      tog_in = (state_q == APPLY) && ten_q;
   end

   toggle_state_fsm #(
      .RESET_STATE (RESET_STATE)
   ) u_toggle (
      .clk    (clk),
      .areset (areset),
      .in     (tog_in),
      .out    (state_out)
   );

endmodule

// File: tb/tb_toggle_arb_sched.sv
// Bench for toggle_arb_sched: vector table of isolated transactions plus hand sequences
// for fairness, reset mid-transaction and (with TOGGLE_ARB_LOCK_EN) locked re-grants.
module tb_toggle_arb_sched;

   logic       clk = 1'b0;
   logic       areset;
   logic [3:0] req;
   logic [3:0] toggle_en;
`ifdef TOGGLE_ARB_LOCK_EN
   logic [3:0] lock;
`endif
   logic [3:0] gnt;
   logic       done;
   logic       state_out;
   logic       busy;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [3:0] gnt;
      logic       st;
   } exp_t;

   typedef struct {
      logic [3:0] req;
      logic [3:0] ten;
      logic [3:0] gnt;
      logic       st;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[8];

   always #5 clk = ~clk;

   toggle_arb_sched #(
      .NREQ        (4),
      .RESET_STATE (1'b1)
   ) dut (
      .clk       (clk),
      .areset    (areset),
      .req       (req),
      .toggle_en (toggle_en),
`ifdef TOGGLE_ARB_LOCK_EN
      .lock      (lock),
`endif
      .gnt       (gnt),
      .done      (done),
      .state_out (state_out),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Every done pops the oldest expected grant/state and compares.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("done with empty scoreboard", sb_q.size(), 1);
         end else begin
            e = sb_q.pop_front();
            chk("done gnt", gnt, e.gnt);
            chk("done state_out", state_out, e.st);
         end
      end
   end

   task automatic do_reset;
      areset    = 1'b1;
      req       = '0;
      toggle_en = '0;
`ifdef TOGGLE_ARB_LOCK_EN
      lock      = '0;
`endif
      tick;
      tick;
      chk("reset gnt", gnt, 0);
      chk("reset done", done, 0);
      chk("reset busy", busy, 0);
      chk("reset state_out", state_out, 1);
      areset = 1'b0;
   endtask

   // Isolated transaction: req dropped in GRANT, toggle_en scrambled after GRANT.
   task automatic txn(input logic [3:0] r, input logic [3:0] t, input logic [3:0] eg,
                      input logic es, input logic ps);
      req       = r;
      toggle_en = t;
      sb_q.push_back('{gnt: eg, st: es});
      tick;
      chk("c1 gnt", gnt, eg);
      chk("c1 done", done, 0);
      chk("c1 busy", busy, 1);
      req = '0;
      tick;
      toggle_en = ~t;
      chk("c2 gnt", gnt, eg);
      chk("c2 state_out", state_out, ps);
      tick;
      chk("c3 gnt", gnt, eg);
      tick;
      chk("c4 busy", busy, 0);
      chk("c4 gnt", gnt, 0);
      toggle_en = '0;
   endtask

   initial begin
      logic       ps;
      logic [3:0] eg;

      areset    = 1'b1;
      req       = '0;
      toggle_en = '0;
`ifdef TOGGLE_ARB_LOCK_EN
      lock      = '0;
`endif
      //          req      ten      gnt      state after
      vecs[0] = '{4'b0010, 4'b0010, 4'b0010, 1'b0};
      vecs[1] = '{4'b0001, 4'b0000, 4'b0001, 1'b0};
      vecs[2] = '{4'b1001, 4'b1111, 4'b1000, 1'b1};
      vecs[3] = '{4'b1001, 4'b0001, 4'b0001, 1'b0};
      vecs[4] = '{4'b0110, 4'b0100, 4'b0010, 1'b0};
      vecs[5] = '{4'b0110, 4'b0100, 4'b0100, 1'b1};
      vecs[6] = '{4'b0111, 4'b0000, 4'b0001, 1'b1};
      vecs[7] = '{4'b1111, 4'b1111, 4'b0010, 1'b0};

      do_reset();

      ps = 1'b1;
      for (int i = 0; i < 8; i++) begin
         txn(vecs[i].req, vecs[i].ten, vecs[i].gnt, vecs[i].st, ps);
         ps = vecs[i].st;
      end

      // All four requesting: strict rotation, done every third cycle.
      do_reset();
      req       = 4'b1111;
      toggle_en = 4'b1010;
      sb_q.push_back('{gnt: 4'b0001, st: 1'b1});
      sb_q.push_back('{gnt: 4'b0010, st: 1'b0});
      sb_q.push_back('{gnt: 4'b0100, st: 1'b0});
      sb_q.push_back('{gnt: 4'b1000, st: 1'b1});
      for (int c = 1; c <= 12; c++) begin
         tick;
         if (c == 11) req = '0;
         eg = 4'b0001 << ((c - 1) / 3);
         chk("rr gnt", gnt, eg);
         chk("rr done", done, (c % 3 == 0) ? 1 : 0);
      end
      tick;
      chk("rr idle busy", busy, 0);
      toggle_en = '0;

      // Reset while in APPLY: no done, no toggle, pointer back to 0.
      do_reset();
      req       = 4'b0100;
      toggle_en = 4'b0100;
      tick;
      req = '0;
      tick;
      chk("apply gnt", gnt, 4'b0100);
      areset = 1'b1;
      tick;
      chk("mid-reset done", done, 0);
      chk("mid-reset gnt", gnt, 0);
      chk("mid-reset busy", busy, 0);
      chk("mid-reset state_out", state_out, 1);
      areset    = 1'b0;
      toggle_en = '0;
      txn(4'b1010, 4'b0000, 4'b0010, 1'b1, 1'b1);

`ifdef TOGGLE_ARB_LOCK_EN
      // Locked requester 0 gets two full passes, then requester 2.
      do_reset();
      req  = 4'b0101;
      lock = 4'b0001;
      sb_q.push_back('{gnt: 4'b0001, st: 1'b1});
      sb_q.push_back('{gnt: 4'b0001, st: 1'b1});
      sb_q.push_back('{gnt: 4'b0100, st: 1'b1});
      for (int c = 1; c <= 9; c++) begin
         tick;
         if (c == 4) lock = '0;
         if (c == 7) req = '0;
         chk("lock gnt", gnt, (c <= 6) ? 4'b0001 : 4'b0100);
         chk("lock done", done, (c % 3 == 0) ? 1 : 0);
      end
      tick;
      chk("lock idle busy", busy, 0);
`endif

      tick;
      tick;
      chk("scoreboard drained", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
